// File: rtl/bubble_load_scheduler_pkg.sv
// ============================================================================
// Module      : bubble_load_scheduler_pkg
// Description : Shared FSM encoding, load-kind constants and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bubble_load_scheduler_pkg;

    localparam int C_DEF_PAGE_WIDTH  = 12;
    localparam int C_DEF_IMAGE_WIDTH = 3;

    localparam logic C_KIND_BOOT = 1'b1;
    localparam logic C_KIND_PAGE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bubble_load_scheduler_if.sv
// ============================================================================
// Module      : bubble_load_scheduler_if
// Description : Request, SPI-loader command and buffer-status signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bubble_load_scheduler_if
    import bubble_load_scheduler_pkg::*;
#(
    parameter int PAGE_WIDTH  = C_DEF_PAGE_WIDTH,
    parameter int IMAGE_WIDTH = C_DEF_IMAGE_WIDTH
) ();

    logic [IMAGE_WIDTH-1:0] image_number;
    logic                   boot_req;
    logic                   page_req;
    logic [PAGE_WIDTH-1:0]  page_number;
    logic                   loader_done;
    logic                   load_bootloader;
    logic                   load_page;
    logic [PAGE_WIDTH-1:0]  load_page_number;
    logic                   buffer_valid;
    logic                   buffer_is_boot;
    logic [PAGE_WIDTH-1:0]  buffer_page;
    logic                   busy;
    logic                   hit;
    logic                   timeout_error;

    modport master (
        output image_number, boot_req, page_req, page_number, loader_done,
        input  load_bootloader, load_page, load_page_number, buffer_valid,
               buffer_is_boot, buffer_page, busy, hit, timeout_error
    );

    modport slave (
        input  image_number, boot_req, page_req, page_number, loader_done,
        output load_bootloader, load_page, load_page_number, buffer_valid,
               buffer_is_boot, buffer_page, busy, hit, timeout_error
    );

endinterface

`default_nettype wire

// File: rtl/bubble_load_scheduler_timeout.sv
// ============================================================================
// Module      : load_timeout_counter
// Description : Clearable up-counter flagging the cycle it reaches the limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_timeout_counter
    import bubble_load_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_terminal
);

    localparam logic [TIMEOUT_WIDTH-1:0] C_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TIMEOUT_WIDTH'(1);
        end
    end

    // Flags the enabled cycle whose increment makes the count reach the limit.
    assign o_terminal = i_enable && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/bubble_load_scheduler.sv
// ============================================================================
// Module      : bubble_load_scheduler
// Description : Arbitrates boot/page load requests to the SPI loader, tags the
//               page buffer and suppresses redundant page loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bubble_load_scheduler
    import bubble_load_scheduler_pkg::*;
#(
    parameter int PAGE_WIDTH     = C_DEF_PAGE_WIDTH,
    parameter int IMAGE_WIDTH    = C_DEF_IMAGE_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  wire logic                master_clock,
    input  wire logic                reset,
    bubble_load_scheduler_if.slave   bus
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_boot_pend;
    logic                    r_page_pend;
    logic [PAGE_WIDTH-1:0]   r_pend_page;
    logic                    r_kind;
    logic [IMAGE_WIDTH-1:0]  r_image;
    logic                    r_image_dirty;
    logic                    w_hit;
    logic                    w_image_change;
    logic                    w_start_boot;
    logic                    w_start_page;
    logic                    w_timeout;

    assign w_image_change = (bus.image_number != r_image);
    assign w_hit          = bus.page_req && bus.buffer_valid && !bus.buffer_is_boot &&
                            (bus.buffer_page == bus.page_number) &&
                            (r_state == ST_IDLE) && !r_boot_pend;
    assign w_start_boot   = (r_state == ST_IDLE) && r_boot_pend;
    assign w_start_page   = (r_state == ST_IDLE) && !r_boot_pend && r_page_pend;
    assign bus.busy       = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

    load_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk        (master_clock),
        .rst        (reset),
        .i_clear    (r_state == ST_ISSUE),
        .i_enable   (r_state == ST_WAIT),
        .o_terminal (w_timeout)
    );

    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (r_boot_pend || r_page_pend) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                // A completion arriving on the timeout cycle still counts.
                if (bus.loader_done)    w_next_state = ST_DONE;
                else if (w_timeout)     w_next_state = ST_IDLE;
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_boot_pend          <= 1'b0;
            r_page_pend          <= 1'b0;
            r_pend_page          <= '0;
            r_kind               <= C_KIND_PAGE;
            r_image              <= '0;
            r_image_dirty        <= 1'b0;
            bus.load_bootloader  <= 1'b0;
            bus.load_page        <= 1'b0;
            bus.load_page_number <= '0;
            bus.buffer_valid     <= 1'b0;
            bus.buffer_is_boot   <= 1'b0;
            bus.buffer_page      <= '0;
            bus.hit              <= 1'b0;
            bus.timeout_error    <= 1'b0;
        end else begin
            r_image             <= bus.image_number;
            r_boot_pend         <= bus.boot_req || (r_boot_pend && !w_start_boot);
            r_page_pend         <= (bus.page_req && !w_hit) || (r_page_pend && !w_start_page);
            if (bus.page_req && !w_hit) begin
                r_pend_page <= bus.page_number;
            end
            bus.hit             <= w_hit;
            bus.load_bootloader <= w_start_boot;
            bus.load_page       <= w_start_page;

            if (w_start_boot) begin
                r_kind               <= C_KIND_BOOT;
                bus.load_page_number <= '0;
            end else if (w_start_page) begin
                r_kind               <= C_KIND_PAGE;
                bus.load_page_number <= r_pend_page;
            end

            // Remembers an image switch that happened while a load was in flight.
            if (r_state == ST_IDLE) begin
                r_image_dirty <= 1'b0;
            end else if (w_image_change) begin
                r_image_dirty <= 1'b1;
            end

            if (r_state == ST_DONE) begin
                bus.buffer_valid   <= !(r_image_dirty || w_image_change);
                bus.buffer_is_boot <= r_kind;
                bus.buffer_page    <= (r_kind == C_KIND_BOOT) ? '0 : bus.load_page_number;
                bus.timeout_error  <= 1'b0;
            end else if (w_image_change || w_start_boot || w_start_page) begin
                bus.buffer_valid   <= 1'b0;
            end

            if ((r_state == ST_WAIT) && !bus.loader_done && w_timeout) begin
                bus.timeout_error <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bubble_load_scheduler.sv
// ============================================================================
// Module      : tb_bubble_load_scheduler
// Description : Directed vector table plus multi-cycle sequences for the
//               bubble load scheduler (timeout shortened to 100 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bubble_load_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bubble_load_scheduler_if #(.PAGE_WIDTH(12), .IMAGE_WIDTH(3)) bus ();

    bubble_load_scheduler #(
        .PAGE_WIDTH     (12),
        .IMAGE_WIDTH    (3),
        .TIMEOUT_CYCLES (100),
        .TIMEOUT_WIDTH  (16)
    ) dut (
        .master_clock (clk),
        .reset        (rst),
        .bus          (bus)
    );

    typedef struct {
        logic        boot;
        logic        page;
        logic [11:0] pn;
        logic        done;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packed order: load_bootloader, load_page, load_page_number, buffer_valid,
    // buffer_is_boot, buffer_page, busy, hit, timeout_error.
    function automatic logic [31:0] mk(logic lb, logic lp, logic [11:0] lpn, logic v,
                                       logic ib, logic [11:0] bp, logic bsy,
                                       logic h, logic te);
        return {1'b0, lb, lp, lpn, v, ib, bp, bsy, h, te};
    endfunction

    function automatic logic [31:0] obs();
        return {1'b0, bus.load_bootloader, bus.load_page, bus.load_page_number,
                bus.buffer_valid, bus.buffer_is_boot, bus.buffer_page,
                bus.busy, bus.hit, bus.timeout_error};
    endfunction

    task automatic add(logic b, logic p, logic [11:0] pn, logic d,
                       logic lb, logic lp, logic [11:0] lpn, logic v, logic ib,
                       logic [11:0] bp, logic bsy, logic h, logic te);
        vec_t t;
        t.boot = b; t.page = p; t.pn = pn; t.done = d;
        t.exp  = mk(lb, lp, lpn, v, ib, bp, bsy, h, te);
        vecs.push_back(t);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic req_page(input logic [11:0] p);
        bus.page_req    = 1'b1;
        bus.page_number = p;
        cyc();
        bus.page_req    = 1'b0;
        bus.page_number = '0;
    endtask

    // Loader model answering each command one cycle after its pulse.
    task automatic run_auto(input int n, input logic first_done,
                            output int pulses, output logic [11:0] last);
        logic prev;
        prev   = first_done;
        pulses = 0;
        last   = '0;
        for (int k = 0; k < n; k++) begin
            if (bus.load_page) begin
                pulses++;
                last = bus.load_page_number;
            end
            if (bus.load_bootloader) pulses++;
            bus.loader_done = prev;
            prev = bus.load_page || bus.load_bootloader;
            cyc();
        end
        bus.loader_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          busy_cnt;
        int          pulses;
        logic [11:0] last;

        bus.image_number = '0;
        bus.boot_req     = 1'b0;
        bus.page_req     = 1'b0;
        bus.page_number  = '0;
        bus.loader_done  = 1'b0;
        rst = 1'b1;
        cyc(); cyc(); cyc();
        check("reset_state", obs(), 32'd0);
        rst = 1'b0;

        //   boot page pn      done  lb lp lpn     v  ib bp      busy hit te
        add(0, 0, 12'h000, 0,   0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0);
        add(0, 1, 12'h123, 0,   0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0);
        add(0, 0, 12'h000, 0,   0, 1, 12'h123, 0, 0, 12'h000, 1, 0, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h123, 0, 0, 12'h000, 1, 0, 0);
        add(0, 0, 12'h000, 1,   0, 0, 12'h123, 0, 0, 12'h000, 0, 0, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h123, 1, 0, 12'h123, 0, 0, 0);
        add(0, 1, 12'h123, 0,   0, 0, 12'h123, 1, 0, 12'h123, 0, 1, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h123, 1, 0, 12'h123, 0, 0, 0);
        add(0, 1, 12'h124, 0,   0, 0, 12'h123, 1, 0, 12'h123, 0, 0, 0);
        add(0, 0, 12'h000, 0,   0, 1, 12'h124, 0, 0, 12'h123, 1, 0, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h124, 0, 0, 12'h123, 1, 0, 0);
        add(0, 0, 12'h000, 1,   0, 0, 12'h124, 0, 0, 12'h123, 0, 0, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h124, 1, 0, 12'h124, 0, 0, 0);
        add(1, 1, 12'h045, 0,   0, 0, 12'h124, 1, 0, 12'h124, 0, 0, 0);
        add(0, 0, 12'h000, 0,   1, 0, 12'h000, 0, 0, 12'h124, 1, 0, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h000, 0, 0, 12'h124, 1, 0, 0);
        add(0, 0, 12'h000, 1,   0, 0, 12'h000, 0, 0, 12'h124, 0, 0, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h000, 1, 1, 12'h000, 0, 0, 0);
        add(0, 0, 12'h000, 0,   0, 1, 12'h045, 0, 1, 12'h000, 1, 0, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h045, 0, 1, 12'h000, 1, 0, 0);
        add(0, 0, 12'h000, 1,   0, 0, 12'h045, 0, 1, 12'h000, 0, 0, 0);
        add(0, 0, 12'h000, 0,   0, 0, 12'h045, 1, 0, 12'h045, 0, 0, 0);
        add(0, 1, 12'h045, 0,   0, 0, 12'h045, 1, 0, 12'h045, 0, 1, 0);

        foreach (vecs[i]) begin
            bus.boot_req    = vecs[i].boot;
            bus.page_req    = vecs[i].page;
            bus.page_number = vecs[i].pn;
            bus.loader_done = vecs[i].done;
            cyc();
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end
        bus.boot_req = 1'b0; bus.page_req = 1'b0; bus.page_number = '0; bus.loader_done = 1'b0;

        // Completion 20 cycles after the command pulse.
        req_page(12'h200);
        cyc();
        check("a_latency_pulse", 32'(bus.load_page), 32'd1);
        busy_cnt = 0; pulses = 0;
        for (int k = 0; k < 25; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.load_page) pulses++;
            bus.loader_done = (k == 20);
            cyc();
        end
        bus.loader_done = 1'b0;
        check("a_busy_cycles", 32'(busy_cnt), 32'd21);
        check("a_pulses", 32'(pulses), 32'd1);
        check("a_lpn", 32'(bus.load_page_number), 32'h200);
        check("a_buffer", {19'd0, bus.buffer_valid, bus.buffer_page}, {19'd0, 1'b1, 12'h200});

        // Requests arriving while busy coalesce to the latest page.
        req_page(12'h010);
        cyc();
        check("b_first_lpn", {19'd0, bus.load_page, bus.load_page_number}, {19'd0, 1'b1, 12'h010});
        bus.page_req = 1'b1; bus.page_number = 12'h011;
        cyc();
        bus.page_number = 12'h012;
        cyc();
        bus.page_req = 1'b0;
        run_auto(12, 1'b1, pulses, last);
        check("b_extra_loads", 32'(pulses), 32'd1);
        check("b_extra_lpn", 32'(last), 32'h012);
        check("b_buffer", {18'd0, bus.buffer_valid, bus.buffer_is_boot, bus.buffer_page},
              {18'd0, 1'b1, 1'b0, 12'h012});

        // No completion: timeout after 100 WAIT cycles.
        req_page(12'h300);
        cyc();
        check("c_pulse", 32'(bus.load_page), 32'd1);
        busy_cnt = 0;
        for (int k = 0; k < 120; k++) begin
            if (bus.busy) busy_cnt++;
            cyc();
        end
        check("c_busy_cycles", 32'(busy_cnt), 32'd101);
        check("c_timeout_state", {29'd0, bus.timeout_error, bus.buffer_valid, bus.busy},
              {29'd0, 1'b1, 1'b0, 1'b0});
        req_page(12'h301);
        cyc();
        check("c_sticky", 32'(bus.timeout_error), 32'd1);
        run_auto(8, 1'b0, pulses, last);
        check("c_cleared", {18'd0, bus.timeout_error, bus.buffer_valid, bus.buffer_page},
              {18'd0, 1'b0, 1'b1, 12'h301});

        // Image switch while waiting invalidates the completed load.
        req_page(12'h055);
        cyc();
        cyc();
        bus.image_number = 3'd1;
        cyc();
        bus.loader_done = 1'b1;
        cyc();
        bus.loader_done = 1'b0;
        cyc();
        check("d_invalid", {30'd0, bus.buffer_valid, bus.busy}, 32'd0);
        req_page(12'h055);
        check("d_no_hit", 32'(bus.hit), 32'd0);
        cyc();
        check("d_reload", 32'(bus.load_page), 32'd1);
        run_auto(8, 1'b0, pulses, last);
        check("d_valid", {19'd0, bus.buffer_valid, bus.buffer_page}, {19'd0, 1'b1, 12'h055});

        // Reset in WAIT abandons the load; a late completion is ignored.
        req_page(12'h066);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("e_reset_mid_load", obs(), 32'd0);
        bus.loader_done = 1'b1;
        cyc();
        bus.loader_done = 1'b0;
        check("e_late_done", obs(), 32'd0);
        cyc();
        check("e_still_idle", obs(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
